// File: rtl/tank_pkg.sv
// Shared constants and FSM state types for the PS/2 keyboard front end of the tank controller.
// Build option: PS2_PARITY_CHECK_EN enables odd-parity checking in ps2_rx_frame.
package tank_pkg;

   localparam logic [7:0] KEY_W     = 8'h77;
   localparam logic [7:0] KEY_A     = 8'h61;
   localparam logic [7:0] KEY_S     = 8'h73;
   localparam logic [7:0] KEY_D     = 8'h64;
   localparam logic [7:0] KEY_SPACE = 8'h20;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_W      = 8'h1D;
   localparam logic [7:0] SC_A      = 8'h1C;
   localparam logic [7:0] SC_S      = 8'h1B;
   localparam logic [7:0] SC_D      = 8'h23;
   localparam logic [7:0] SC_SPACE  = 8'h29;
   localparam logic [7:0] SC_UP     = 8'h75;
   localparam logic [7:0] SC_LEFT   = 8'h6B;
   localparam logic [7:0] SC_DOWN   = 8'h72;
   localparam logic [7:0] SC_RIGHT  = 8'h74;

   typedef enum logic [1:0] {
      FS_IDLE,
      FS_DATA,
      FS_PARITY,
      FS_STOP
   } frame_state_t;

   typedef enum logic [1:0] {
      DS_NORM,
      DS_EXT,
      DS_BRK,
      DS_EXT_BRK
   } dec_state_t;

   typedef struct packed {
      logic       hit;
      logic [7:0] code;
   } key_map_t;

   // Arrow keys alias onto the WASD codes so the direction stage sees one key set.
   function automatic key_map_t map_key(input logic ext, input logic [7:0] sc);
      key_map_t m;
      m.hit  = 1'b1;
      m.code = 8'h00;
      if (ext) begin
         case (sc)
            SC_UP:    m.code = KEY_W;
            SC_LEFT:  m.code = KEY_A;
            SC_DOWN:  m.code = KEY_S;
            SC_RIGHT: m.code = KEY_D;
            default:  m.hit  = 1'b0;
         endcase
      end else begin
         case (sc)
            SC_W:     m.code = KEY_W;
            SC_A:     m.code = KEY_A;
            SC_S:     m.code = KEY_S;
            SC_D:     m.code = KEY_D;
            SC_SPACE: m.code = KEY_SPACE;
            default:  m.hit  = 1'b0;
         endcase
      end
      return m;
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 pin synchroniser, clock glitch filter and 11-bit frame receiver with inactivity timeout.
// Build option: PS2_PARITY_CHECK_EN drops bytes whose odd parity does not hold.
module ps2_rx_frame
   import tank_pkg::*;
#(
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       byte_vld,
   output logic [7:0] byte_data,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

   logic          clk_s1, clk_s2, data_s1, data_s2;
   logic [FW-1:0] filt_cnt;
   logic          filt, filt_q;
   logic          fall;
   frame_state_t  state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic [TW-1:0] tout;
   logic          par_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1   <= 1'b0;
         clk_s2   <= 1'b0;
         data_s1  <= 1'b0;
         data_s2  <= 1'b0;
         filt_cnt <= '0;
         filt     <= 1'b0;
         filt_q   <= 1'b0;
      end else begin
         clk_s1  <= ps2_clk;
         clk_s2  <= clk_s1;
         data_s1 <= ps2_data;
         data_s2 <= data_s1;
         filt_q  <= filt;
         // The filtered level flips only after FILTER_LEN samples in a row disagree with it.
         if (clk_s2 == filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == F_LAST) begin
            filt_cnt <= '0;
            filt     <= clk_s2;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   assign fall = filt_q & ~filt;

`ifdef PS2_PARITY_CHECK_EN
   logic par_bit;
   assign par_ok = ^{shift, par_bit};
`else
   assign par_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FS_IDLE;
         bit_cnt   <= '0;
         shift     <= '0;
         tout      <= '0;
         byte_vld  <= 1'b0;
         byte_data <= '0;
         frame_err <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         par_bit   <= 1'b0;
`endif
      end else begin
         byte_vld  <= 1'b0;
         frame_err <= 1'b0;
         // A falling edge always takes priority over an expiring timeout.
         if (fall) begin
            tout <= '0;
            case (state)
               FS_IDLE: begin
                  if (!data_s2) begin
                     state   <= FS_DATA;
                     bit_cnt <= '0;
                  end
               end
               FS_DATA: begin
                  shift   <= {data_s2, shift[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= FS_PARITY;
               end
               FS_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                  par_bit <= data_s2;
`endif
                  state   <= FS_STOP;
               end
               default: begin
                  state <= FS_IDLE;
                  if (data_s2 && par_ok) begin
                     byte_vld  <= 1'b1;
                     byte_data <= shift;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
            endcase
         end else if (state == FS_IDLE) begin
            tout <= '0;
         end else if (tout == T_LAST) begin
            tout      <= '0;
            state     <= FS_IDLE;
            frame_err <= 1'b1;
         end else begin
            tout <= tout + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 make/break decoder mapping driving keys to lowercase ASCII with a held-key flag.
// Build option: PS2_PARITY_CHECK_EN (forwarded to ps2_rx_frame) adds parity errors to frame_err.
module ps2_key_decoder
   import tank_pkg::*;
#(
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] ascii,
   output logic       press,
   output logic       key_evt,
   output logic       frame_err
);

   logic       byte_vld;
   logic [7:0] byte_data;
   dec_state_t dstate;
   logic       is_ext, is_brk;
   key_map_t   mapped;

   ps2_rx_frame #(
      .FILTER_LEN  (FILTER_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_rx (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .byte_vld  (byte_vld),
      .byte_data (byte_data),
      .frame_err (frame_err)
   );

   assign is_ext = (dstate == DS_EXT) || (dstate == DS_EXT_BRK);
   assign is_brk = (dstate == DS_BRK) || (dstate == DS_EXT_BRK);
   assign mapped = map_key(is_ext, byte_data);

   always_ff @(posedge clk) begin
      if (rst) begin
         dstate  <= DS_NORM;
         ascii   <= 8'h00;
         press   <= 1'b0;
         key_evt <= 1'b0;
      end else begin
         key_evt <= 1'b0;
         if (byte_vld) begin
            if (dstate == DS_NORM && byte_data == SC_EXT) begin
               dstate <= DS_EXT;
            end else if (!is_brk && byte_data == SC_BRK) begin
               dstate <= is_ext ? DS_EXT_BRK : DS_BRK;
            end else begin
               dstate <= DS_NORM;
               if (mapped.hit) begin
                  // Typematic repeats of the held key are swallowed; only real changes pulse key_evt.
                  if (!is_brk) begin
                     if (!press || ascii != mapped.code) begin
                        ascii   <= mapped.code;
                        press   <= 1'b1;
                        key_evt <= 1'b1;
                     end
                  end else if (press && ascii == mapped.code) begin
                     press   <= 1'b0;
                     key_evt <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: 1 MHz system clock, 10 kHz PS/2 clock, hand-computed expectations.
// Build option: PS2_PARITY_CHECK_EN selects the expected outcome of the bad-parity step.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] ascii;
   logic       press;
   logic       key_evt;
   logic       frame_err;

   int tests = 0;
   int fails = 0;
   int evt_cnt = 0;
   int err_cnt = 0;
   int coin_cnt = 0;
   int evt_base, err_base;

   ps2_key_decoder #(
      .FILTER_LEN  (4),
      .TIMEOUT_CYC (1000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .ascii     (ascii),
      .press     (press),
      .key_evt   (key_evt),
      .frame_err (frame_err)
   );

   always #500 clk = ~clk;

   always @(posedge clk) begin
      if (key_evt === 1'b1) evt_cnt <= evt_cnt + 1;
      if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
      if (key_evt === 1'b1 && frame_err === 1'b1) coin_cnt <= coin_cnt + 1;
   end

   task automatic check(input string tag, input int got, input int exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic mark();
      evt_base = evt_cnt;
      err_base = err_cnt;
   endtask

   // One PS/2 bit: data set while clock is high, 50 us low phase.
   task automatic ps2_bit(input logic b);
      ps2_data = b;
      repeat (25) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (50) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (25) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic flip_par);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ flip_par);
      ps2_bit(stop_bit);
      ps2_data = 1'b1;
   endtask

   task automatic send(input logic [7:0] b);
      send_frame(b, 1'b1, 1'b0);
   endtask

   task automatic send_partial(input int n);
      ps2_bit(1'b0);
      for (int i = 0; i < n; i++) ps2_bit(1'b1);
      ps2_data = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_ascii", int'(ascii), 8'h00);
      check("reset_press", int'(press), 0);
      check("reset_key_evt", int'(key_evt), 0);
      check("reset_frame_err", int'(frame_err), 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      mark();
      send(8'h1D);
      check("w_make_ascii", int'(ascii), 8'h77);
      check("w_make_press", int'(press), 1);
      check("w_make_evt", evt_cnt - evt_base, 1);
      mark();
      send(8'hF0); send(8'h1D);
      check("w_brk_ascii", int'(ascii), 8'h77);
      check("w_brk_press", int'(press), 0);
      check("w_brk_evt", evt_cnt - evt_base, 1);

      mark();
      send(8'hE0); send(8'h6B);
      send(8'hE0); send(8'h6B);
      check("left_ascii", int'(ascii), 8'h61);
      check("left_press", int'(press), 1);
      check("left_repeat_evt", evt_cnt - evt_base, 1);
      mark();
      send(8'hE0); send(8'hF0); send(8'h6B);
      check("left_brk_press", int'(press), 0);
      check("left_brk_evt", evt_cnt - evt_base, 1);

      mark();
      send(8'h1C);
      check("a_make_ascii", int'(ascii), 8'h61);
      check("a_make_press", int'(press), 1);
      send(8'h23);
      check("d_make_ascii", int'(ascii), 8'h64);
      check("d_make_evt", evt_cnt - evt_base, 2);
      send(8'hF0); send(8'h1C);
      check("a_brk_press", int'(press), 1);
      check("a_brk_ascii", int'(ascii), 8'h64);
      check("a_brk_evt", evt_cnt - evt_base, 2);
      send(8'hF0); send(8'h23);
      check("d_brk_press", int'(press), 0);
      check("d_brk_evt", evt_cnt - evt_base, 3);

      mark();
      send(8'h15); send(8'hF0); send(8'h15); send(8'hAA);
      check("unmapped_ascii", int'(ascii), 8'h64);
      check("unmapped_press", int'(press), 0);
      check("unmapped_evt", evt_cnt - evt_base, 0);
      check("unmapped_err", err_cnt - err_base, 0);

      mark();
      send_frame(8'h1D, 1'b0, 1'b0);
      check("stop0_err", err_cnt - err_base, 1);
      check("stop0_ascii", int'(ascii), 8'h64);
      check("stop0_evt", evt_cnt - evt_base, 0);

      mark();
      send_partial(4);
      repeat (1200) @(negedge clk);
      check("timeout_err", err_cnt - err_base, 1);
      send(8'h1B);
      check("after_timeout_ascii", int'(ascii), 8'h73);
      check("after_timeout_press", int'(press), 1);
      check("after_timeout_err", err_cnt - err_base, 1);

      mark();
      send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
      check("badpar_err", err_cnt - err_base, 1);
      check("badpar_ascii", int'(ascii), 8'h73);
      check("badpar_evt", evt_cnt - evt_base, 0);
`else
      check("badpar_err", err_cnt - err_base, 0);
      check("badpar_ascii", int'(ascii), 8'h61);
      check("badpar_evt", evt_cnt - evt_base, 1);
`endif
      check("badpar_press", int'(press), 1);

      mark();
      send_partial(3);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_ascii", int'(ascii), 8'h00);
      check("midrst_press", int'(press), 0);
      check("midrst_key_evt", int'(key_evt), 0);
      check("midrst_frame_err", int'(frame_err), 0);
      repeat (20) @(negedge clk);
      mark();
      send(8'h29);
      check("space_ascii", int'(ascii), 8'h20);
      check("space_press", int'(press), 1);
      check("space_evt", evt_cnt - evt_base, 1);
      check("space_err", err_cnt - err_base, 0);
      check("evt_err_coincide", coin_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives raw PS/2 keyboard frames and turns them into the `ascii` / `press` pair consumed by the tank direction stage. It sits directly upstream of that stage. It performs pin synchronisation and glitch filtering, bit-level frame reception, and scan-code set 2 make/break decoding. It maps the driving keys (W/A/S/D, the arrow keys and space) to lowercase ASCII and holds `press` high for as long as the tracked key stays down.

## Interface
- `FILTER_LEN`, default 4: consecutive identical samples needed before a filtered `ps2_clk` level changes.
- `TIMEOUT_CYC`, default 50000: `clk` cycles without a falling `ps2_clk` edge before a partial frame is abandoned.
- `clk` in, 1 bit: system clock.
- `rst` in, 1 bit: synchronous, active-high reset.
- `ps2_clk` in, 1 bit: asynchronous PS/2 clock pin.
- `ps2_data` in, 1 bit: asynchronous PS/2 data pin.
- `ascii` out, 8 bits: ASCII code of the last accepted mapped key.
- `press` out, 1 bit: high while the key shown on `ascii` is held.
- `key_evt` out, 1 bit: one-cycle pulse whenever `ascii` or `press` changes.
- `frame_err` out, 1 bit: one-cycle pulse on a framing error, parity error or timeout.

## Operation
- **Input path**
  - Both pins pass through a 2-FF synchroniser.
  - `ps2_clk` then passes through the `FILTER_LEN` filter.
  - A falling edge of the filtered clock samples the synchronised `ps2_data`.
- **Frame FSM** (states: IDLE, DATA, PARITY, STOP)
  - IDLE: waits for a falling edge with data 0 (start bit). Data 1 on a falling edge stays in IDLE and raises no error.
  - DATA: shifts in 8 bits, LSB first, with a 3-bit counter. Goes to PARITY after bit 7.
  - PARITY: captures the parity bit.
  - STOP: the stop bit must be 1.
    - Stop bit 1: pulses internal `byte_vld` with the byte, then returns to IDLE.
    - Stop bit 0: pulses `frame_err`, then returns to IDLE.
  - Timeout: a timeout counter runs in every state except IDLE and clears on each falling edge. When it reaches `TIMEOUT_CYC`, the FSM goes to IDLE, pulses `frame_err` and discards the byte.
- **Decode FSM** (states: NORM, EXT, BRK, EXT_BRK), consuming `byte_vld`:
  - `E0` moves NORM to EXT.
  - `F0` moves NORM to BRK, and EXT to EXT_BRK.
  - Any other byte is a make code in NORM or EXT and a break code in BRK or EXT_BRK. The FSM returns to NORM after it.
- **Key map**
  - Plain codes: `1D`→`77`, `1C`→`61`, `1B`→`73`, `23`→`64`, `29`→`20`.
  - Extended codes: `E0 75`→`77`, `E0 6B`→`61`, `E0 72`→`73`, `E0 74`→`64`.
  - Every other code is unmapped and ignored. It never changes the outputs, but it still advances the decode FSM.
- **Key tracking**
  - Mapped make, `press` low or a different key: `ascii` takes the new code, `press` goes to 1, `key_evt` pulses.
  - Mapped make of the same key while held (typematic repeat): no change and no `key_evt`.
  - Break whose mapped ASCII equals `ascii` while `press` is 1: `press` goes to 0 and `key_evt` pulses. `ascii` keeps its value.
  - Break of any other key: ignored.
- **Bytes not handled:** `AA` (self-test pass) and `FA` (ack) are unmapped and therefore ignored.

## Timing
- Reset values: `ascii` = `8'h00`, `press` = 0, `key_evt` = 0, `frame_err` = 0. Both FSMs go to IDLE/NORM, and all counters and the filter go to 0.
- `rst` asserted in the middle of a frame drops the partial byte. The next frame must begin with a fresh start bit.
- Pin-to-edge latency is 2 synchroniser cycles plus `FILTER_LEN` cycles.
- `byte_vld` is registered the cycle after the stop-bit edge is detected.
- `ascii`, `press` and `key_evt` update the cycle after `byte_vld`. Total output latency is therefore 2 cycles after the stop-bit edge.
- A `frame_err` timeout and a falling edge can arrive in the same cycle. The edge wins: the counter clears and no error is raised.
- `key_evt` and `frame_err` can never coincide, because they are triggered by different bytes.

## Configuration
- `PS2_PARITY_CHECK_EN` defined:
  - PARITY checks for odd parity over the 8 data bits plus the parity bit.
  - On a mismatch, the byte is dropped at STOP and `frame_err` pulses.
- `PS2_PARITY_CHECK_EN` undefined:
  - The parity bit is sampled and discarded.
  - Only the start bit, the stop bit and the timeout can cause errors.

## Structure
- Shared package `tank_pkg` holds:
  - ASCII constants `KEY_W` (`8'h77`), `KEY_A` (`8'h61`), `KEY_S` (`8'h73`), `KEY_D` (`8'h64`), `KEY_SPACE` (`8'h20`).
  - Scan-code constants `SC_EXT` (`E0`) and `SC_BRK` (`F0`), plus the make codes listed above.
  - Enum typedefs for both FSMs.
- Sub-module `ps2_rx_frame` contains the synchroniser, the filter, the frame FSM and the timeout, and outputs `byte_vld`, `byte` and `frame_err`.
- The top level contains the decode FSM, the key map and the output registers.

## Test plan
- Frame `1D`, then `F0 1D`, with a 10 kHz PS/2 clock: `ascii` = `77`, `press` = 1 with one `key_evt`; then `press` = 0, `ascii` stays `77`, second `key_evt`.
- `E0 6B`, `E0 6B` (repeat), then `E0 F0 6B`: `ascii` = `61`, `press` = 1 with exactly one `key_evt` for the two makes; the break clears `press`.
- Make `1C`, make `23`, break `1C`, break `23`: `ascii` goes `61` then `64`. `press` stays 1 through break `1C` and falls only on break `23`.
- Unmapped `15`, then `F0 15`, then `AA`: outputs unchanged, no `key_evt`.
- Errors:
  - Stop bit forced to 0 → `frame_err` pulse, no decode.
  - Clock stalled after 4 bits for longer than `TIMEOUT_CYC` → `frame_err`, then the next full frame `1B` decodes to `73`.
  - With `PS2_PARITY_CHECK_EN`, a bad parity bit → `frame_err` and the byte is dropped.
- `rst` pulsed in the middle of a frame while `press` = 1 → all outputs at reset values the next cycle; the following clean `29` gives `ascii` = `20`, `press` = 1.
